// File: rtl/pixel_frame_writer_if.sv
// Pixel-write and flip handshake between a frame producer and the display controller.
// The master drives pixels and flip requests; the slave supplies enable and the flip acknowledge.
interface pixel_frame_writer_if;
  logic       enable;
  logic       flipped;
  logic [3:0] x;
  logic [2:0] y;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       valid;
  logic       flip;
  logic       busy;
  logic       frame_done;

  modport master (
    input  enable,
    input  flipped,
    output x,
    output y,
    output red,
    output green,
    output blue,
    output valid,
    output flip,
    output busy,
    output frame_done
  );

  modport slave (
    output enable,
    output flipped,
    input  x,
    input  y,
    input  red,
    input  green,
    input  blue,
    input  valid,
    input  flip,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/pixel_frame_writer.sv
// Writes a 16x8 horizontally scrolling gradient frame, one pixel per cycle, then flips buffers,
// waits for the acknowledge and idles for FRAME_DELAY cycles before the next frame.
module pixel_frame_writer #(
  parameter int unsigned FRAME_DELAY = 1250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_frame_writer_if.master bus_io
);

  localparam int unsigned CntW = (FRAME_DELAY > 0) ? $clog2(FRAME_DELAY + 1) : 1;
  localparam logic [CntW-1:0] DelayLoad = (FRAME_DELAY > 0) ? CntW'(FRAME_DELAY - 1) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StFlip,
    StWaitFlip,
    StDelay
  } state_e;

  state_e          state_q;
  logic [3:0]      x_q;
  logic [2:0]      y_q;
  logic [3:0]      offset_q;
  logic [7:0]      red_q;
  logic [7:0]      green_q;
  logic [7:0]      blue_q;
  logic            valid_q;
  logic            flip_q;
  logic            busy_q;
  logic            frame_done_q;
  logic [CntW-1:0] cnt_q;

  logic [3:0]  x_adv;
  logic [2:0]  y_adv;
  logic [3:0]  offset_inc;
  logic        last_pix;
  logic [23:0] col_adv;
  logic [23:0] col_start;
  logic [23:0] col_start_inc;

  // Packed {red, green, blue}; red <= 8'hF0 so blue never underflows.
  function automatic logic [23:0] pixel_colour(input logic [3:0] px, input logic [2:0] py,
                                               input logic [3:0] off);
    logic [3:0] p;
    logic [7:0] r;
    p = px + off;
    r = {p, 4'h0};
    return {r, py, 5'h00, 8'hF0 - r};
  endfunction

  always_comb begin
    x_adv         = x_q + 4'd1;
    y_adv         = (x_q == 4'd15) ? y_q + 3'd1 : y_q;
    last_pix      = (x_q == 4'd15) && (y_q == 3'd7);
    offset_inc    = offset_q + 4'd1;
    col_adv       = pixel_colour(x_adv, y_adv, offset_q);
    col_start     = pixel_colour(4'd0, 3'd0, offset_q);
    // With no delay the next frame starts in the acknowledge cycle, before offset_q updates.
    col_start_inc = pixel_colour(4'd0, 3'd0, offset_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x_q          <= 4'd0;
      y_q          <= 3'd0;
      offset_q     <= 4'd0;
      red_q        <= 8'd0;
      green_q      <= 8'd0;
      blue_q       <= 8'd0;
      valid_q      <= 1'b0;
      flip_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= 1'b0;
      flip_q       <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.enable) begin
            state_q                   <= StWrite;
            x_q                       <= 4'd0;
            y_q                       <= 3'd0;
            {red_q, green_q, blue_q}  <= col_start;
            valid_q                   <= 1'b1;
            busy_q                    <= 1'b1;
          end
        end
        StWrite: begin
          if (last_pix) begin
            state_q <= StFlip;
            flip_q  <= 1'b1;
          end else begin
            x_q                      <= x_adv;
            y_q                      <= y_adv;
            {red_q, green_q, blue_q} <= col_adv;
            valid_q                  <= 1'b1;
          end
        end
        StFlip: begin
          state_q <= StWaitFlip;
        end
        StWaitFlip: begin
          if (bus_io.flipped) begin
            frame_done_q <= 1'b1;
            offset_q     <= offset_inc;
            if (FRAME_DELAY == 0) begin
              if (bus_io.enable) begin
                state_q                  <= StWrite;
                x_q                      <= 4'd0;
                y_q                      <= 3'd0;
                {red_q, green_q, blue_q} <= col_start_inc;
                valid_q                  <= 1'b1;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              state_q <= StDelay;
              cnt_q   <= DelayLoad;
            end
          end
        end
        StDelay: begin
          if (cnt_q == '0) begin
            if (bus_io.enable) begin
              state_q                  <= StWrite;
              x_q                      <= 4'd0;
              y_q                      <= 3'd0;
              {red_q, green_q, blue_q} <= col_start;
              valid_q                  <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.x          = x_q;
  assign bus_io.y          = y_q;
  assign bus_io.red        = red_q;
  assign bus_io.green      = green_q;
  assign bus_io.blue       = blue_q;
  assign bus_io.valid      = valid_q;
  assign bus_io.flip       = flip_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.frame_done = frame_done_q;

endmodule

// File: doc/pixel_frame_writer.md
# pixel_frame_writer

Frame producer on the write side of `dipslay_controller`'s pixel/flip interface on the clock shield. It writes a full 16x8 RGB frame (display 1 = x 0..7, display 2 = x 8..15), one pixel per cycle, into the controller's back buffer. It then requests a buffer swap with `flip`, waits for `flipped`, and holds for a programmable inter-frame delay. The pattern is a horizontally scrolling colour gradient, which makes it the bring-up and fallback source for the display path.

## Interface
Parameters:
- `FRAME_DELAY`, default 1250000: idle cycles after each acknowledged flip (25 ms at 50 MHz). A value of 0 means no delay. Counter width is `$clog2(FRAME_DELAY+1)`, minimum 1.

Ports:
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  reset; synchronous, active-low
- `enable`  in  1  run request; sampled in IDLE and at the end of DELAY
- `flipped`  in  1  one-cycle pulse from the display controller: buffers swapped
- `x`  out  4  pixel column 0..15
- `y`  out  3  pixel row 0..7
- `red`, `green`, `blue`  out  8 each  pixel colour
- `valid`  out  1  pixel write strobe; consumer accepts every cycle, there is no back-pressure
- `flip`  out  1  one-cycle swap request
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse when `flipped` is accepted

## Operation
- All outputs are registered.
- Reset values: `x`=0, `y`=0, colour=0, `valid`=0, `flip`=0, `busy`=0, `frame_done`=0, `offset`=0, state IDLE, delay counter 0.
- Reset mid-frame aborts immediately. The next cycle shows reset values and no further `valid` or `flip`.
- States:
  - IDLE: if `enable`, go to WRITE with (x,y)=(0,0).
  - WRITE: `valid`=1 each cycle. x increments; when x wraps 15->0, y increments. After the cycle presenting (15,7), go to FLIP. `enable` is ignored during WRITE; a started frame always completes.
  - FLIP: `flip`=1 for exactly one cycle, `valid`=0, then go to WAIT_FLIP.
  - WAIT_FLIP:
    - Wait with no timeout for `flipped`=1.
    - On `flipped`: `frame_done`=1 for one cycle and `offset`<=`offset`+1 mod 16.
    - Then go to DELAY with counter=`FRAME_DELAY`-1. If `FRAME_DELAY`=0, go straight to the end-of-delay decision instead.
  - DELAY: count down. In the cycle the counter equals 0, go to WRITE at (0,0) if `enable`, otherwise go to IDLE.
- `flipped` outside WAIT_FLIP (including the FLIP cycle itself) is ignored.
- No pixel write may occur between a `flip` pulse and its `flipped`.
- Colour rule, evaluated combinationally from the next (x,y) and registered with it:
  - p = (x + offset) mod 16, using 4-bit wrap
  - red = {p, 4'h0}
  - green = {y, 5'h00}
  - blue = 8'hF0 - red, which never underflows since red ≤ 8'hF0
- When `valid`=0, `x`, `y` and colour hold their last values. Consumers must ignore them.

## Timing
- `enable` high in IDLE at edge N gives the first `valid` (0,0) at N+1.
- A frame is exactly 128 consecutive `valid` cycles, with no gaps.
- `flip` is asserted in the cycle immediately after the last `valid`.
- `flipped` seen at edge M gives `frame_done` at M+1 and state DELAY from M+1.
- Next frame's first `valid` appears at M+1+`FRAME_DELAY`.
  - With `FRAME_DELAY`=0 it appears at M+1, and `frame_done` coincides with the first `valid`.
- Frame period (continuous enable, `flipped` latency L cycles after `flip`) is 128 + 1 + L + `FRAME_DELAY` cycles.
- `busy` rises with the first `valid` and falls in the cycle IDLE is re-entered.

## Test plan
- Reset/idle: hold `rst_n`=0 for 3 cycles, then release with `enable`=0 for 50 cycles. Required: all outputs stay 0 and `busy`=0 throughout.
- Single frame, `FRAME_DELAY`=4, `flipped` returned 3 cycles after `flip`:
  - Exactly 128 `valid` cycles, scanned x-fastest: (0,0),(1,0)..(15,0),(0,1)..(15,7).
  - Pixel (5,2) = R 8'h50, G 8'h40, B 8'hA0.
  - One `flip` immediately after (15,7); `frame_done` one cycle after `flipped`.
- Scroll wrap: run 17 frames. Required: frame k has pixel (0,0) red = {k mod 16, 4'h0}; frame 16 repeats frame 0 exactly.
- Stray/late handshake:
  - `flipped` pulsed during WRITE and during the FLIP cycle: ignored, and no `frame_done`.
  - Withholding `flipped` for 1000 cycles: no `valid`, no second `flip`, `busy`=1.
- Enable drop:
  - Deassert `enable` mid-WRITE: frame completes all 128 pixels and handshake, then IDLE after DELAY with `busy`=0.
  - Reassert `enable`: first `valid` one cycle later.
- Reset mid-operation: assert `rst_n`=0 at pixel 60, and separately in WAIT_FLIP. Required: reset values the next cycle, `offset`=0, and the next frame restarts at (0,0) with p=x.
